// File: rtl/gobang_pkg.sv
// gobang_pkg
// Shared definitions for the gobang move sequencer and its neighbours:
// board geometry, player and winner encodings, the sequencer state enum
// and the row/col -> bitmap index helper.
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;

    // move_count is 8 bits wide; full board value in that width.
    localparam logic [7:0] CELLS_U8 = 8'(CELLS);

    typedef enum logic {
        BLACK = 1'b0,
        WHITE = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_BLACK = 2'b01,
        WIN_WHITE = 2'b10,
        WIN_DRAW  = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Bitmap index = row*15 + col. row*15 is formed as row*16 - row so
    // only a shift and a subtract are needed; the result fits in 8 bits
    // for any 4-bit row/col (max 15*15+15 = 240).
    function automatic logic [7:0] cell_idx(input logic [3:0] row,
                                            input logic [3:0] col);
        return ({row, 4'b0000} - {4'b0000, row}) + {4'b0000, col};
    endfunction

endpackage

// File: rtl/gobang_move_ctrl_if.sv
// gobang_move_ctrl_if
// Placement request channel between the input/UI layer (master) and the
// move sequencer (slave).
//   place_req  master->slave  request a stone at (place_row, place_col)
//   place_row  master->slave  requested row, 0..14 valid
//   place_col  master->slave  requested column, 0..14 valid
//   place_rdy  slave->master  request will be sampled this cycle
//   place_ack  slave->master  one-cycle pulse: move accepted and evaluated
//   place_err  slave->master  one-cycle pulse: move rejected
//
// Handshake: a request is taken on a rising edge where place_req and
// place_rdy are both high; row/col must be stable in that cycle. A request
// while place_rdy is low is ignored (no response at all). Every taken
// request gets exactly one response: place_err in the following cycle, or
// place_ack two cycles later once the move has been evaluated.
interface gobang_move_ctrl_if;

    logic       place_req;
    logic [3:0] place_row;
    logic [3:0] place_col;
    logic       place_rdy;
    logic       place_ack;
    logic       place_err;

    modport master (
        output place_req, place_row, place_col,
        input  place_rdy, place_ack, place_err
    );

    modport slave (
        input  place_req, place_row, place_col,
        output place_rdy, place_ack, place_err
    );

endinterface

// File: rtl/gobang_cell_decode.sv
// gobang_cell_decode
// Combinational row/col decoder shared by the move sequencer and the
// display cursor logic.
//   row, col  in   4-bit board coordinates
//   idx       out  bitmap index row*15+col (meaningful only when in_range)
//   in_range  out  both coordinates are within 0..14
module gobang_cell_decode
    import gobang_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] idx,
    output logic       in_range
);

    assign idx      = cell_idx(row, col);
    assign in_range = (row < 4'(BOARD_N)) && (col < 4'(BOARD_N));

endmodule

// File: rtl/gobang_move_ctrl.sv
// gobang_move_ctrl
// Turn and move sequencer for the 15x15 gobang board. Validates placement
// requests, owns both occupancy bitmaps, drives the external direction
// checkers with the newest stone and declares win / draw / next turn.
//   clk, rst_n      clock, synchronous active-low reset
//   new_game        synchronous clear of the whole game, any state
//   place           placement request channel (slave side)
//   board_black     black occupancy, bit = row*15+col
//   board_white     white occupancy, same indexing
//   cur_player      side to move (0 black, 1 white)
//   chk_row/col     coordinates presented to the direction checkers
//   chk_board       mover's bitmap presented to the direction checkers
//   win_h/v/d/a     direction checker results, sampled in CHECK only
//   game_over       high in OVER
//   winner          00 none, 01 black, 10 white, 11 draw
//   move_count      stones on the board, saturates at 225
//   dbg_state       current sequencer state
module gobang_move_ctrl
    import gobang_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    gobang_move_ctrl_if.slave  place,
    output logic [CELLS-1:0]   board_black,
    output logic [CELLS-1:0]   board_white,
    output logic               cur_player,
    output logic [3:0]         chk_row,
    output logic [3:0]         chk_col,
    output logic [CELLS-1:0]   chk_board,
    input  logic               win_h,
    input  logic               win_v,
    input  logic               win_d,
    input  logic               win_a,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [7:0]         move_count,
    output state_t             dbg_state
);

    state_t           state;
    player_t          mover;
    winner_t          winner_q;
    logic             win_q;
    logic             ack_q;
    logic             err_q;

    logic [7:0]       req_idx;
    logic             req_in_range;
    logic [CELLS-1:0] cell_mask;
    logic             occupied;
    logic             accept;

    gobang_cell_decode u_decode (
        .row      (place.place_row),
        .col      (place.place_col),
        .idx      (req_idx),
        .in_range (req_in_range)
    );

    // Out-of-range indices (>=225) shift the single bit off the top, so the
    // mask is all-zero and cannot touch either bitmap.
    assign cell_mask = CELLS'(1) << req_idx;
    assign occupied  = |((board_black | board_white) & cell_mask);
    assign accept    = req_in_range && !occupied;

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state       <= S_IDLE;
            mover       <= BLACK;
            winner_q    <= WIN_NONE;
            win_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            board_black <= '0;
            board_white <= '0;
            move_count  <= '0;
            chk_row     <= '0;
            chk_col     <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (place.place_req) begin
                        if (accept) begin
                            if (mover == BLACK) begin
                                board_black <= board_black | cell_mask;
                            end else begin
                                board_white <= board_white | cell_mask;
                            end
                            if (move_count != CELLS_U8) begin
                                move_count <= move_count + 8'd1;
                            end
                            chk_row <= place.place_row;
                            chk_col <= place.place_col;
                            state   <= S_CHECK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // Checkers are combinational on chk_*; their answer for
                    // the new stone is valid by the end of this cycle.
                    win_q <= win_h | win_v | win_d | win_a;
                    ack_q <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (win_q) begin
                        winner_q <= (mover == BLACK) ? WIN_BLACK : WIN_WHITE;
                        state    <= S_OVER;
                    end else if (move_count == CELLS_U8) begin
                        winner_q <= WIN_DRAW;
                        state    <= S_OVER;
                    end else begin
                        mover <= (mover == BLACK) ? WHITE : BLACK;
                        state <= S_IDLE;
                    end
                end
                S_OVER: begin
                    // Board is frozen; keep the UI unblocked but refuse moves.
                    if (place.place_req) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign place.place_rdy = (state == S_IDLE) || (state == S_OVER);
    assign place.place_ack = ack_q;
    assign place.place_err = err_q;

    // The mover does not change until the end of DONE, so following the
    // side to move yields the mover's bitmap (with the new stone) in CHECK.
    assign chk_board  = (mover == WHITE) ? board_white : board_black;

    assign cur_player = mover;
    assign game_over  = (state == S_OVER);
    assign winner     = winner_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_gobang_move_ctrl.sv
module tb_gobang_move_ctrl;
    import gobang_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic new_game;
    always #5 clk = ~clk;

    gobang_move_ctrl_if pif ();

    logic [CELLS-1:0] board_black, board_white, chk_board;
    logic             cur_player, game_over;
    logic [3:0]       chk_row, chk_col;
    logic [1:0]       winner;
    logic [7:0]       move_count;
    state_t           dbg_state;
    logic             win_h, win_v, win_d, win_a;
    logic             stub_zero;

    gobang_move_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_game    (new_game),
        .place       (pif),
        .board_black (board_black),
        .board_white (board_white),
        .cur_player  (cur_player),
        .chk_row     (chk_row),
        .chk_col     (chk_col),
        .chk_board   (chk_board),
        .win_h       (win_h),
        .win_v       (win_v),
        .win_d       (win_d),
        .win_a       (win_a),
        .game_over   (game_over),
        .winner      (winner),
        .move_count  (move_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- direction checker model ----------------
    function automatic int run_len(input logic [CELLS-1:0] b, input int r,
                                   input int c, input int dr, input int dc);
        int n  = 0;
        int rr = r + dr;
        int cc = c + dc;
        while (rr >= 0 && rr < BOARD_N && cc >= 0 && cc < BOARD_N && b[rr*BOARD_N+cc]) begin
            n++;
            rr += dr;
            cc += dc;
        end
        return n;
    endfunction

    always_comb begin
        win_h = 1'b0;
        win_v = 1'b0;
        win_d = 1'b0;
        win_a = 1'b0;
        if (!stub_zero) begin
            win_h = (1 + run_len(chk_board, int'(chk_row), int'(chk_col), 0, 1)
                       + run_len(chk_board, int'(chk_row), int'(chk_col), 0, -1)) >= 5;
            win_v = (1 + run_len(chk_board, int'(chk_row), int'(chk_col), 1, 0)
                       + run_len(chk_board, int'(chk_row), int'(chk_col), -1, 0)) >= 5;
            win_d = (1 + run_len(chk_board, int'(chk_row), int'(chk_col), 1, 1)
                       + run_len(chk_board, int'(chk_row), int'(chk_col), -1, -1)) >= 5;
            win_a = (1 + run_len(chk_board, int'(chk_row), int'(chk_col), 1, -1)
                       + run_len(chk_board, int'(chk_row), int'(chk_col), -1, 1)) >= 5;
        end
    end

    // ---------------- scoreboard ----------------
    int               n_checks = 0;
    int               n_err    = 0;
    logic [7:0]       exp_q[$];
    logic [CELLS-1:0] exp_black, exp_white;
    int               exp_count;
    logic             exp_player;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_black  = '0;
        exp_white  = '0;
        exp_count  = 0;
        exp_player = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"}, 256'(dbg_state), 256'(S_IDLE));
        check({tag, ".black"}, 256'(board_black), 256'(0));
        check({tag, ".white"}, 256'(board_white), 256'(0));
        check({tag, ".player"}, 256'(cur_player), 256'(0));
        check({tag, ".count"}, 256'(move_count), 256'(0));
        check({tag, ".winner"}, 256'(winner), 256'(0));
        check({tag, ".over"}, 256'(game_over), 256'(0));
        check({tag, ".ack"}, 256'(pif.place_ack), 256'(0));
        check({tag, ".err"}, 256'(pif.place_err), 256'(0));
        check({tag, ".chk_row"}, 256'(chk_row), 256'(0));
        check({tag, ".chk_col"}, 256'(chk_col), 256'(0));
        check({tag, ".rdy"}, 256'(pif.place_rdy), 256'(1));
    endtask

    // ---------------- drivers ----------------
    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
    endtask

    // Accepted move; exp_win is the winner code expected after DONE.
    // With stray=1 a second request is raised while place_rdy is low.
    task automatic move_accept(input int r, input int c, input logic [1:0] exp_win,
                               input bit stray);
        int idx = r * BOARD_N + c;
        @(negedge clk);
        pif.place_req = 1'b1;
        pif.place_row = 4'(r);
        pif.place_col = 4'(c);
        @(negedge clk);                       // cycle N+1: CHECK
        pif.place_req = 1'b0;
        if (exp_player == 1'b0) exp_black[idx] = 1'b1;
        else                    exp_white[idx] = 1'b1;
        exp_count++;
        exp_q.push_back(8'(exp_count));
        check("acc.state_check", 256'(dbg_state), 256'(S_CHECK));
        check("acc.err", 256'(pif.place_err), 256'(0));
        check("acc.rdy_low", 256'(pif.place_rdy), 256'(0));
        check("acc.chk_row", 256'(chk_row), 256'(r));
        check("acc.chk_col", 256'(chk_col), 256'(c));
        check("acc.chk_board", 256'(chk_board[idx]), 256'(1));
        check("acc.black", 256'(board_black), 256'(exp_black));
        check("acc.white", 256'(board_white), 256'(exp_white));
        if (stray) begin
            pif.place_req = 1'b1;
            pif.place_row = 4'd5;
            pif.place_col = 4'd5;
        end
        @(negedge clk);                       // cycle N+2: DONE
        pif.place_req = 1'b0;
        check("acc.ack", 256'(pif.place_ack), 256'(1));
        check("acc.count", 256'(move_count), 256'(exp_q.pop_front()));
        @(negedge clk);                       // cycle N+3
        if (exp_win == 2'b00) exp_player = ~exp_player;
        check("acc.ack_pulse", 256'(pif.place_ack), 256'(0));
        check("acc.err_after", 256'(pif.place_err), 256'(0));
        check("acc.winner", 256'(winner), 256'(exp_win));
        check("acc.over", 256'(game_over), 256'(exp_win != 2'b00));
        check("acc.player", 256'(cur_player), 256'(exp_player));
        check("acc.rdy", 256'(pif.place_rdy), 256'(1));
        check("acc.black_after", 256'(board_black), 256'(exp_black));
        check("acc.white_after", 256'(board_white), 256'(exp_white));
    endtask

    task automatic move_reject(input int r, input int c, input state_t exp_state);
        @(negedge clk);
        pif.place_req = 1'b1;
        pif.place_row = 4'(r);
        pif.place_col = 4'(c);
        @(negedge clk);                       // cycle N+1
        pif.place_req = 1'b0;
        check("rej.err", 256'(pif.place_err), 256'(1));
        check("rej.ack", 256'(pif.place_ack), 256'(0));
        check("rej.rdy", 256'(pif.place_rdy), 256'(1));
        check("rej.state", 256'(dbg_state), 256'(exp_state));
        check("rej.black", 256'(board_black), 256'(exp_black));
        check("rej.white", 256'(board_white), 256'(exp_white));
        check("rej.count", 256'(move_count), 256'(exp_count));
        check("rej.player", 256'(cur_player), 256'(exp_player));
        @(negedge clk);
        check("rej.err_pulse", 256'(pif.place_err), 256'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        new_game      = 1'b0;
        stub_zero     = 1'b0;
        pif.place_req = 1'b0;
        pif.place_row = 4'd0;
        pif.place_col = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset("reset");

        // First move in the centre: bit 112.
        move_accept(7, 7, 2'b00, 1'b0);
        check("center.bit112", 256'(board_black[112]), 256'(1));

        // White move with a stray request during CHECK/DONE that must vanish.
        move_accept(1, 2, 2'b00, 1'b1);
        check("stray.cell55", 256'(board_white[5*15+5] | board_black[5*15+5]), 256'(0));

        // Occupied cell and out-of-range requests.
        do_new_game();
        move_accept(0, 0, 2'b00, 1'b0);
        move_reject(0, 0, S_IDLE);
        check("occ.white_empty", 256'(board_white), 256'(0));
        move_reject(15, 3, S_IDLE);
        move_reject(3, 15, S_IDLE);

        // Diagonal win for black; white stays at four in a row.
        do_new_game();
        move_accept(0, 0, 2'b00, 1'b0);
        move_accept(0, 5, 2'b00, 1'b0);
        move_accept(1, 1, 2'b00, 1'b0);
        move_accept(0, 6, 2'b00, 1'b0);
        move_accept(2, 2, 2'b00, 1'b0);
        move_accept(0, 7, 2'b00, 1'b0);
        move_accept(3, 3, 2'b00, 1'b0);
        move_accept(0, 8, 2'b00, 1'b0);
        move_accept(4, 4, 2'b01, 1'b0);
        move_reject(10, 10, S_OVER);
        check("win.still_over", 256'(game_over), 256'(1));

        // new_game and place_req in the same cycle: new_game wins.
        @(negedge clk);
        new_game      = 1'b1;
        pif.place_req = 1'b1;
        pif.place_row = 4'd6;
        pif.place_col = 4'd6;
        @(negedge clk);
        new_game      = 1'b0;
        pif.place_req = 1'b0;
        model_reset();
        check_reset("ng_prio");

        // new_game while in CHECK: no ack, full reset, same cell then accepted.
        @(negedge clk);
        pif.place_req = 1'b1;
        pif.place_row = 4'd7;
        pif.place_col = 4'd7;
        @(negedge clk);
        pif.place_req = 1'b0;
        check("ng_check.in_check", 256'(dbg_state), 256'(S_CHECK));
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        check_reset("ng_check");
        move_accept(7, 7, 2'b00, 1'b0);

        // Draw: fill the board in index order with checkers forced to 0.
        do_new_game();
        stub_zero = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            move_accept(i / BOARD_N, i % BOARD_N, (i == CELLS - 1) ? 2'b11 : 2'b00, 1'b0);
        end
        check("draw.count", 256'(move_count), 256'(225));
        check("draw.winner", 256'(winner), 256'(3));
        check("draw.full", 256'(board_black | board_white), 256'({CELLS{1'b1}}));
        move_reject(14, 14, S_OVER);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
